mcu_link_rx: RTL

- ROCSTAR-side receiver for the 4-bit MCU→ROCSTAR cable stream, directly downstream of the MCU per-cable transmitter.
- Word-aligns to the rotating idle pattern and decodes prompt-coincidence and no-coincidence symbols into one-cycle pulses.
- Reassembles 16-bit special command words and counts protocol errors for register-bus readout.

---
 rtl/mcu_link_pkg.sv | 81 ++++++++
 rtl/mcu_link_lockdet.sv | 42 ++++
 rtl/mcu_link_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU->ROCSTAR 4-bit cable link: wire symbols,
// receiver state/class enums and the locked-mode successor rule.
package mcu_link_pkg;

  localparam logic [3:0] SYM_IDLE0 = 4'b0111;
  localparam logic [3:0] SYM_IDLE1 = 4'b1011;
  localparam logic [3:0] SYM_IDLE2 = 4'b1101;
  localparam logic [3:0] SYM_IDLE3 = 4'b1110;
  localparam logic [3:0] SYM_NCOIN = 4'b1001;
  localparam logic [3:0] SYM_PCOIN = 4'b0011;
  localparam logic [3:0] SYM_SPECL = 4'b1100;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LOCKED,
    ST_PAY1,
    ST_PAY2,
    ST_PAY3,
    ST_PAY4
  } rx_state_e;

  // SC_SPEC4 marks a just-completed special word; SC_OTHER is any unknown nibble.
  typedef enum logic [3:0] {
    SC_IDLE0,
    SC_IDLE1,
    SC_IDLE2,
    SC_IDLE3,
    SC_NCOIN,
    SC_PCOIN,
    SC_SPECL,
    SC_SPEC4,
    SC_OTHER
  } sym_class_e;

  function automatic sym_class_e classify(input logic [3:0] sym);
    sym_class_e c;
    case (sym)
      SYM_IDLE0: c = SC_IDLE0;
      SYM_IDLE1: c = SC_IDLE1;
      SYM_IDLE2: c = SC_IDLE2;
      SYM_IDLE3: c = SC_IDLE3;
      SYM_NCOIN: c = SC_NCOIN;
      SYM_PCOIN: c = SC_PCOIN;
      SYM_SPECL: c = SC_SPECL;
      default:   c = SC_OTHER;
    endcase
    return c;
  endfunction

  function automatic logic is_idle(input sym_class_e c);
    return (c == SC_IDLE0) || (c == SC_IDLE1) || (c == SC_IDLE2) || (c == SC_IDLE3);
  endfunction

  function automatic sym_class_e idle_succ(input sym_class_e c);
    sym_class_e n;
    case (c)
      SC_IDLE0: n = SC_IDLE1;
      SC_IDLE1: n = SC_IDLE2;
      SC_IDLE2: n = SC_IDLE3;
      SC_IDLE3: n = SC_IDLE0;
      default:  n = SC_OTHER;
    endcase
    return n;
  endfunction

  function automatic logic next_legal(input sym_class_e last, input sym_class_e sym);
    logic ok;
    case (last)
      SC_IDLE0, SC_IDLE1, SC_IDLE2, SC_IDLE3:
        ok = (sym == idle_succ(last)) || (sym == SC_NCOIN) || (sym == SC_PCOIN) || (sym == SC_SPECL);
      SC_NCOIN, SC_PCOIN:
        ok = (sym == SC_IDLE0) || (sym == SC_SPECL);
      SC_SPEC4:
        ok = (sym == SC_IDLE0) || (sym == SC_NCOIN) || (sym == SC_PCOIN) || (sym == SC_SPECL);
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mcu_link_lockdet.sv
// Idle-succession checker for the HUNT phase: counts consecutive correct idle
// rotations and flags the succession that completes the lock requirement.
module mcu_link_lockdet
  import mcu_link_pkg::*;
#(
  parameter int LOCK_N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hunt_en,
  input  sym_class_e last_cls,
  input  sym_class_e cur_cls,
  output logic       lock_ok
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_N - 1);

  logic [3:0] cnt_r;
  logic [3:0] cnt_s;
  logic       succ_s;

  // Succession check and next hunt count; the count only survives while hunting.
  always_comb begin
    succ_s  = is_idle(last_cls) && (cur_cls == idle_succ(last_cls));
    lock_ok = hunt_en && succ_s && (cnt_r == LOCK_LAST);
    if (!hunt_en || !succ_s || lock_ok) begin
      cnt_s = 4'd0;
    end else begin
      cnt_s = cnt_r + 4'd1;
    end
  end

  // Hunt counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/mcu_link_rx.sv
// ROCSTAR-side receiver for the MCU cable stream: idle alignment, coincidence
// symbol decode, special-word reassembly and a saturating protocol-error count.
module mcu_link_rx
  import mcu_link_pkg::*;
#(
  parameter int LOCK_N = 8,
  parameter int ERRW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in,
  input  logic            err_clr,
  output logic            locked,
  output logic            pcoinc,
  output logic            ncoinc,
  output logic            spw_valid,
  output logic [15:0]     spw_data,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [ERRW-1:0] CNT_ONE = ERRW'(1'b1);
  localparam logic [ERRW-1:0] CNT_MAX = {ERRW{1'b1}};

  logic [3:0]      in_q_r;
  rx_state_e       state_r, state_s;
  sym_class_e      last_r, last_s;
  sym_class_e      cls_s;
  logic [11:0]     shift_r, shift_s;
  logic [15:0]     data_r, data_s;
  logic            locked_r, locked_s;
  logic            pcoinc_r, pcoinc_s;
  logic            ncoinc_r, ncoinc_s;
  logic            spw_valid_r, spw_valid_s;
  logic            err_r, err_s;
  logic [ERRW-1:0] err_cnt_r, err_cnt_s;
  logic            lock_ok_s;

  assign cls_s = classify(in_q_r);

  mcu_link_lockdet #(.LOCK_N(LOCK_N)) u_lockdet (
    .clk      (clk),
    .rst      (rst),
    .hunt_en  (state_r == ST_HUNT),
    .last_cls (last_r),
    .cur_cls  (cls_s),
    .lock_ok  (lock_ok_s)
  );

  // Receiver FSM: next state, decoded pulses and payload assembly.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    shift_s     = shift_r;
    data_s      = data_r;
    pcoinc_s    = 1'b0;
    ncoinc_s    = 1'b0;
    spw_valid_s = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_HUNT: begin
        last_s = cls_s;
        if (lock_ok_s) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        // An illegal symbol still becomes 'last' so an idle can seed the next hunt.
        last_s = cls_s;
        if (next_legal(last_r, cls_s)) begin
          case (cls_s)
            SC_NCOIN: ncoinc_s = 1'b1;
            SC_PCOIN: pcoinc_s = 1'b1;
            SC_SPECL: state_s  = ST_PAY1;
            default:  state_s  = ST_LOCKED;
          endcase
        end else begin
          err_s   = 1'b1;
          state_s = ST_HUNT;
        end
      end
      ST_PAY1: begin
        shift_s = {shift_r[7:0], in_q_r};
        state_s = ST_PAY2;
      end
      ST_PAY2: begin
        shift_s = {shift_r[7:0], in_q_r};
        state_s = ST_PAY3;
      end
      ST_PAY3: begin
        shift_s = {shift_r[7:0], in_q_r};
        state_s = ST_PAY4;
      end
      ST_PAY4: begin
        data_s      = {shift_r, in_q_r};
        spw_valid_s = 1'b1;
        last_s      = SC_SPEC4;
        state_s     = ST_LOCKED;
      end
      default: begin
        state_s = ST_HUNT;
      end
    endcase
    locked_s = (state_s != ST_HUNT);
  end

  // Saturating error counter; a clear coinciding with a new error leaves one.
  always_comb begin
    if (err_clr && err_s) begin
      err_cnt_s = CNT_ONE;
    end else if (err_clr) begin
      err_cnt_s = {ERRW{1'b0}};
    end else if (err_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_s = err_cnt_r + CNT_ONE;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State, input and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q_r      <= 4'd0;
      state_r     <= ST_HUNT;
      last_r      <= SC_OTHER;
      shift_r     <= 12'd0;
      data_r      <= 16'd0;
      locked_r    <= 1'b0;
      pcoinc_r    <= 1'b0;
      ncoinc_r    <= 1'b0;
      spw_valid_r <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= {ERRW{1'b0}};
    end else begin
      in_q_r      <= in;
      state_r     <= state_s;
      last_r      <= last_s;
      shift_r     <= shift_s;
      data_r      <= data_s;
      locked_r    <= locked_s;
      pcoinc_r    <= pcoinc_s;
      ncoinc_r    <= ncoinc_s;
      spw_valid_r <= spw_valid_s;
      err_r       <= err_s;
      err_cnt_r   <= err_cnt_s;
    end
  end

  assign locked    = locked_r;
  assign pcoinc    = pcoinc_r;
  assign ncoinc    = ncoinc_r;
  assign spw_valid = spw_valid_r;
  assign spw_data  = data_r;
  assign err       = err_r;
  assign err_count = err_cnt_r;

endmodule
